// File: rtl/nav_pkg.sv
// Shared types and constants for the navigation sequencer.
// Build option: NAV_FAST_SIM_EN scales the ramp steps by 16 and lets the
// turn finish on a single in-band heading sample.
package nav_pkg;

  localparam int SPD_W  = 11;
  localparam int HDNG_W = 12;

  // Default speed profile
  localparam logic [SPD_W-1:0] DEF_MAX_SPD  = 11'h2A0;
  localparam logic [SPD_W-1:0] DEF_MIN_SPD  = 11'h0D0;
  localparam logic [SPD_W-1:0] DEF_RAMP_INC = 11'd4;
  localparam logic [SPD_W-1:0] DEF_RAMP_DEC = 11'd8;

`ifdef NAV_FAST_SIM_EN
  localparam int   RAMP_SHIFT   = 4;
  localparam logic TURN_QUAL_ONE = 1'b1;
`else
  localparam int   RAMP_SHIFT   = 0;
  localparam logic TURN_QUAL_ONE = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    ACCEL = 2'd2,
    DECEL = 2'd3
  } nav_state_t;

  typedef enum logic [2:0] {
    RAMP_HOLD     = 3'd0,
    RAMP_LOAD_MIN = 3'd1,
    RAMP_UP       = 3'd2,
    RAMP_DOWN     = 3'd3,
    RAMP_CLR      = 3'd4
  } ramp_op_t;

  typedef logic [2:0] sqr_cnt_t;

  // True once the move has crossed all squares but the last one, which is
  // reserved for braking. Requests of 0 or 1 square brake right away.
  function automatic logic sqrs_reached(input sqr_cnt_t cnt, input sqr_cnt_t cmd);
    return (cmd <= 3'd1) || (cnt == (cmd - 3'd1));
  endfunction

endpackage

// File: rtl/nav_seq_ctrl_spd_ramp.sv
// Forward-speed ramp register: load MIN_SPD, saturating increment,
// floor-to-zero decrement, clear. zero_next warns that a decrement now
// would bottom out, which the sequencer uses to end a deceleration.
module spd_ramp
  import nav_pkg::*;
#(
  parameter logic [SPD_W-1:0] MAX_SPD  = DEF_MAX_SPD,
  parameter logic [SPD_W-1:0] MIN_SPD  = DEF_MIN_SPD,
  parameter logic [SPD_W-1:0] RAMP_INC = DEF_RAMP_INC,
  parameter logic [SPD_W-1:0] RAMP_DEC = DEF_RAMP_DEC
) (
  input  logic             clk,
  input  logic             rst,
  input  ramp_op_t         op,
  output logic [SPD_W-1:0] spd,
  output logic             zero_next
);

  // Step sizes carried one bit wider so the saturation compare cannot wrap
  localparam logic [SPD_W:0] INC_EFF = {1'b0, RAMP_INC} << RAMP_SHIFT;
  localparam logic [SPD_W:0] DEC_EFF = {1'b0, RAMP_DEC} << RAMP_SHIFT;

  logic [SPD_W-1:0] spd_reg;
  logic [SPD_W-1:0] spd_next;
  logic [SPD_W:0]   spd_sum;

  assign spd_sum   = {1'b0, spd_reg} + INC_EFF;
  assign zero_next = ({1'b0, spd_reg} <= DEC_EFF);
  assign spd       = spd_reg;

  // Next-speed selection for the requested ramp operation
  always_comb begin
    spd_next = spd_reg;
    case (op)
      RAMP_LOAD_MIN: spd_next = MIN_SPD;
      RAMP_UP:       spd_next = (spd_sum >= {1'b0, MAX_SPD}) ? MAX_SPD : spd_sum[SPD_W-1:0];
      RAMP_DOWN:     spd_next = zero_next ? '0 : (spd_reg - DEC_EFF[SPD_W-1:0]);
      RAMP_CLR:      spd_next = '0;
      default:       spd_next = spd_reg;
    endcase
  end

  // Speed register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) spd_reg <= '0;
    else     spd_reg <= spd_next;
  end

endmodule

// File: rtl/nav_seq_ctrl.sv
// Navigation sequencer feeding the heading PID: turn-to-heading, then
// ramped forward moves counted in squares, with emergency stop.
// Build option: NAV_FAST_SIM_EN (see nav_pkg) shortens ramps and the turn
// qualifier for system-level simulation.
module nav_seq_ctrl
  import nav_pkg::*;
#(
  parameter logic [SPD_W-1:0] MAX_SPD  = DEF_MAX_SPD,
  parameter logic [SPD_W-1:0] MIN_SPD  = DEF_MIN_SPD,
  parameter logic [SPD_W-1:0] RAMP_INC = DEF_RAMP_INC,
  parameter logic [SPD_W-1:0] RAMP_DEC = DEF_RAMP_DEC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strt_hdng,
  input  logic              strt_mv,
  input  logic [HDNG_W-1:0] cmd_hdng,
  input  logic [2:0]        cmd_sqrs,
  input  logic              sq_pulse,
  input  logic              estop,
  input  logic              hdng_vld,
  input  logic              at_hdng,
  output logic              moving,
  output logic [HDNG_W-1:0] dsrd_hdng,
  output logic [SPD_W-1:0]  frwrd_spd,
  output logic              busy,
  output logic              cmplt
);

  nav_state_t        state_reg, state_next;
  sqr_cnt_t          sq_cnt_reg, sq_cnt_next;
  sqr_cnt_t          sqrs_reg, sqrs_next;
  logic [HDNG_W-1:0] hdng_reg, hdng_next;
  logic              qual_reg, qual_next;
  logic              cmplt_reg, cmplt_next;
  logic              busy_reg;
  logic              moving_reg;
  ramp_op_t          ramp_op;
  logic              zero_next;

  spd_ramp #(
    .MAX_SPD  (MAX_SPD),
    .MIN_SPD  (MIN_SPD),
    .RAMP_INC (RAMP_INC),
    .RAMP_DEC (RAMP_DEC)
  ) u_spd_ramp (
    .clk       (clk),
    .rst       (rst),
    .op        (ramp_op),
    .spd       (frwrd_spd),
    .zero_next (zero_next)
  );

  // Sequencer next-state and ramp-command decode; estop overrides everything
  always_comb begin
    state_next  = state_reg;
    sq_cnt_next = sq_cnt_reg;
    sqrs_next   = sqrs_reg;
    hdng_next   = hdng_reg;
    qual_next   = qual_reg;
    cmplt_next  = 1'b0;
    ramp_op     = RAMP_HOLD;

    if (estop) begin
      state_next = IDLE;
      qual_next  = 1'b0;
      ramp_op    = RAMP_CLR;
    end else begin
      case (state_reg)
        IDLE: begin
          if (strt_hdng) begin
            hdng_next  = cmd_hdng;
            qual_next  = 1'b0;
            state_next = TURN;
          end else if (strt_mv) begin
            sqrs_next   = cmd_sqrs;
            sq_cnt_next = '0;
            state_next  = ACCEL;
          end
        end
        TURN: begin
          if (hdng_vld) begin
            if (at_hdng && (qual_reg || TURN_QUAL_ONE)) begin
              qual_next  = 1'b0;
              cmplt_next = 1'b1;
              state_next = IDLE;
            end else begin
              qual_next = at_hdng;
            end
          end
        end
        ACCEL: begin
          if (sq_pulse) sq_cnt_next = sq_cnt_reg + 3'd1;
          if (hdng_vld) ramp_op = (frwrd_spd == '0) ? RAMP_LOAD_MIN : RAMP_UP;
          // Braking starts only once the ramp has produced its first speed
          if (sqrs_reached(sq_cnt_next, sqrs_reg) && ((frwrd_spd != '0) || hdng_vld))
            state_next = DECEL;
        end
        DECEL: begin
          if (hdng_vld) begin
            if (zero_next) begin
              ramp_op    = RAMP_CLR;
              cmplt_next = 1'b1;
              state_next = IDLE;
            end else begin
              ramp_op = RAMP_DOWN;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      sq_cnt_reg <= '0;
      sqrs_reg   <= '0;
      hdng_reg   <= '0;
      qual_reg   <= 1'b0;
      cmplt_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      moving_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sq_cnt_reg <= sq_cnt_next;
      sqrs_reg   <= sqrs_next;
      hdng_reg   <= hdng_next;
      qual_reg   <= qual_next;
      cmplt_reg  <= cmplt_next;
      busy_reg   <= (state_next != IDLE);
      moving_reg <= (state_next != IDLE);
    end
  end

  assign moving    = moving_reg;
  assign busy      = busy_reg;
  assign cmplt     = cmplt_reg;
  assign dsrd_hdng = hdng_reg;

endmodule

// File: tb/tb_nav_seq_ctrl.sv
// Randomized scoreboard bench for nav_seq_ctrl.
module tb_nav_seq_ctrl;

`ifdef NAV_FAST_SIM_EN
  localparam int QN = 1;
  localparam int K  = 16;
`else
  localparam int QN = 2;
  localparam int K  = 1;
`endif
  localparam int MAXS = 672;
  localparam int MINS = 208;
  localparam int INC  = 4 * K;
  localparam int DEC  = 8 * K;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strt_hdng = 0, strt_mv = 0, sq_pulse = 0, estop = 0, hdng_vld = 0, at_hdng = 0;
  logic [11:0] cmd_hdng = '0;
  logic [2:0]  cmd_sqrs = '0;
  logic        moving, busy, cmplt;
  logic [11:0] dsrd_hdng;
  logic [10:0] frwrd_spd;

  nav_seq_ctrl dut (
    .clk(clk), .rst(rst), .strt_hdng(strt_hdng), .strt_mv(strt_mv),
    .cmd_hdng(cmd_hdng), .cmd_sqrs(cmd_sqrs), .sq_pulse(sq_pulse),
    .estop(estop), .hdng_vld(hdng_vld), .at_hdng(at_hdng),
    .moving(moving), .dsrd_hdng(dsrd_hdng), .frwrd_spd(frwrd_spd),
    .busy(busy), .cmplt(cmplt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    bit          is_cmplt;
    logic [10:0] val;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: mode 0 idle, 1 turning, 2 speeding up, 3 braking
  int m_mode = 0, m_spd = 0, m_qual = 0, m_cnt = 0, m_tgt = 0, m_hdng = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_spd(input int v);
    exp_t e;
    e.is_cmplt = 1'b0;
    e.val = 11'(v);
    exp_q.push_back(e);
  endtask

  task automatic push_cmplt();
    exp_t e;
    e.is_cmplt = 1'b1;
    e.val = '0;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_vld(input bit at);
    int nv;
    hdng_vld = 1'b1;
    at_hdng  = at;
    case (m_mode)
      1: begin
        m_qual = at ? m_qual + 1 : 0;
        if (m_qual >= QN) begin
          push_cmplt();
          m_mode = 0;
        end
      end
      2: begin
        nv = (m_spd == 0) ? MINS : ((m_spd + INC > MAXS) ? MAXS : m_spd + INC);
        if (nv != m_spd) push_spd(nv);
        m_spd = nv;
        if (m_cnt >= m_tgt) m_mode = 3;
      end
      3: begin
        if (m_spd <= DEC) begin
          m_spd = 0;
          push_spd(0);
          push_cmplt();
          m_mode = 0;
        end else begin
          m_spd = m_spd - DEC;
          push_spd(m_spd);
        end
      end
      default: ;
    endcase
    cyc();
    hdng_vld = 1'b0;
    at_hdng  = 1'b0;
  endtask

  task automatic do_sq();
    sq_pulse = 1'b1;
    if (m_mode == 2) begin
      m_cnt++;
      if (m_cnt >= m_tgt && m_spd != 0) m_mode = 3;
    end
    cyc();
    sq_pulse = 1'b0;
  endtask

  // Issue either or both start pulses in one cycle
  task automatic do_starts(input bit sh, input bit sm, input logic [11:0] h, input logic [2:0] n);
    strt_hdng = sh;
    strt_mv   = sm;
    cmd_hdng  = h;
    cmd_sqrs  = n;
    if (m_mode == 0 && !estop) begin
      if (sh) begin
        m_hdng = int'(h);
        m_mode = 1;
        m_qual = 0;
      end else if (sm) begin
        m_mode = 2;
        m_cnt  = 0;
        m_tgt  = (n <= 1) ? 0 : int'(n) - 1;
      end
    end
    cyc();
    strt_hdng = 1'b0;
    strt_mv   = 1'b0;
  endtask

  task automatic gap();
    int g;
    g = $urandom_range(2, 0);
    for (int i = 0; i < g; i++) cyc();
  endtask

  // Monitor: pops the scoreboard on every speed change and every cmplt pulse
  logic [10:0] prev_spd = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_spd = frwrd_spd;
    end else begin
      if (frwrd_spd !== prev_spd) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spd_change: got 0x%0h with nothing expected at %0t", frwrd_spd, $time);
        end else begin
          e = exp_q.pop_front();
          if (e.is_cmplt || e.val !== frwrd_spd) begin
            errors++;
            $display("FAIL spd_step: got 0x%0h expected %s0x%0h at %0t", frwrd_spd,
                     e.is_cmplt ? "cmplt before " : "", e.val, $time);
          end
        end
        prev_spd = frwrd_spd;
      end
      if (cmplt === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL cmplt_pulse: got pulse with nothing expected at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          if (!e.is_cmplt) begin
            errors++;
            $display("FAIL cmplt_pulse: got pulse expected speed 0x%0h at %0t", e.val, $time);
          end
        end
        chk("cmplt_busy_low", int'(busy), 0);
      end
    end
  end

  initial begin
    int n;
    logic [11:0] h;

    // Reset values
    cyc();
    cyc();
    chk("rst_moving", int'(moving), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cmplt", int'(cmplt), 0);
    chk("rst_spd", int'(frwrd_spd), 0);
    chk("rst_hdng", int'(dsrd_hdng), 0);
    rst = 1'b0;
    cyc();

    // Turn to 0x3FF with two qualified samples
    do_starts(1'b1, 1'b0, 12'h3FF, 3'd0);
    chk("turn_hdng", int'(dsrd_hdng), 'h3FF);
    chk("turn_busy", int'(busy), 1);
    chk("turn_moving", int'(moving), 1);
    for (int i = 0; i < QN; i++) begin
      gap();
      do_vld(1'b1);
    end
    cyc();
    $display("txn turn 0x3FF done busy=%0d", busy);
    chk("turn_done_busy", int'(busy), 0);

    // Move of 3 squares: saturating ramp, then two squares and brake
    do_starts(1'b0, 1'b1, 12'h000, 3'd3);
    chk("mv_busy", int'(busy), 1);
    for (int i = 0; i < 200; i++) begin
      do_vld(1'($urandom_range(1, 0)));
      gap();
    end
    chk("mv_sat_spd", int'(frwrd_spd), MAXS);
    $display("txn accel 200 samples spd=0x%0h", frwrd_spd);
    do_sq();
    gap();
    do_sq();
    cyc();
    for (int i = 0; i < 400 && m_mode != 0; i++) begin
      hdng_vld = 1'b0;
      sq_pulse = 1'($urandom_range(1, 0));
      do_vld(1'b0);
      sq_pulse = 1'b0;
      gap();
    end
    cyc();
    $display("txn decel done spd=0x%0h busy=%0d", frwrd_spd, busy);
    chk("mv_done_busy", int'(busy), 0);
    chk("mv_done_moving", int'(moving), 0);
    chk("mv_keeps_hdng", int'(dsrd_hdng), m_hdng);

    // Both starts together: heading wins; a move during TURN is dropped
    h = 12'($urandom_range(4095, 0));
    do_starts(1'b1, 1'b1, h, 3'd2);
    chk("both_hdng", int'(dsrd_hdng), int'(h));
    do_vld(1'b1);
    do_starts(1'b0, 1'b1, 12'h000, 3'd4);
    chk("turn_ignores_mv_spd", int'(frwrd_spd), 0);
    for (int i = 0; i < 60 && m_mode != 0; i++) begin
      do_vld(1'($urandom_range(1, 0)));
      gap();
    end
    cyc();
    $display("txn both-start turn 0x%0h busy=%0d", h, busy);
    chk("both_done_busy", int'(busy), 0);

    // Randomized moves
    for (int m = 0; m < 3; m++) begin
      n = $urandom_range(7, 2);
      do_starts(1'b0, 1'b1, 12'h000, 3'(n));
      for (int i = 0; i < 3000 && m_mode != 0; i++) begin
        case ($urandom_range(3, 0))
          0: do_sq();
          1, 2: do_vld(1'b0);
          default: cyc();
        endcase
      end
      cyc();
      $display("txn rand move sqrs=%0d busy=%0d", n, busy);
      chk("rand_mv_done", int'(busy), 0);
      chk("rand_mv_hdng", int'(dsrd_hdng), m_hdng);
    end

    // Emergency stop at speed 0x150
    do_starts(1'b0, 1'b1, 12'h000, 3'd7);
    for (int i = 0; i < 200 && m_spd != 'h150; i++) do_vld(1'b0);
    chk("estop_pre_spd", int'(frwrd_spd), 'h150);
    estop = 1'b1;
    if (m_spd != 0) push_spd(0);
    m_spd = 0;
    m_mode = 0;
    cyc();
    chk("estop_spd", int'(frwrd_spd), 0);
    chk("estop_moving", int'(moving), 0);
    chk("estop_busy", int'(busy), 0);
    do_starts(1'b0, 1'b1, 12'h000, 3'd3);
    chk("estop_blocks_start", int'(busy), 0);
    estop = 1'b0;
    cyc();
    $display("txn estop busy=%0d spd=0x%0h", busy, frwrd_spd);

    // Zero-square move: MIN_SPD then straight to braking
    do_starts(1'b0, 1'b1, 12'h000, 3'd0);
    do_vld(1'b0);
    chk("sq0_min", int'(frwrd_spd), MINS);
    for (int i = 0; i < 100 && m_mode != 0; i++) do_vld(1'b0);
    cyc();
    $display("txn zero-square move busy=%0d", busy);
    chk("sq0_done", int'(busy), 0);

    // Asynchronous reset during braking
    do_starts(1'b0, 1'b1, 12'h000, 3'd1);
    for (int i = 0; i < 4; i++) do_vld(1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_spd", int'(frwrd_spd), 0);
    chk("arst_moving", int'(moving), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_hdng", int'(dsrd_hdng), 0);
    chk("arst_cmplt", int'(cmplt), 0);
    m_mode = 0;
    m_spd  = 0;
    m_hdng = 0;
    exp_q.delete();
    $display("txn async reset mid-decel spd=0x%0h", frwrd_spd);
    cyc();
    rst = 1'b0;
    cyc();
    cyc();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Runaway guard
  initial begin
    #2000000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

endmodule
